dual_gate_sweep_ctrl: RTL and testbench
=======================================

# dual_gate_sweep_ctrl

Self-test sequencer for the dual 4-input gate block (two independent sections, inputs a–d, output y). On `start` it sweeps all 16 input combinations through both sections, waits a settle interval per vector, and compares each section output against a built-in model of the selected gate function. It reports pass/fail, a mismatch count and the first failing vector. It sits between the lab top level and the gate block, replacing hand-written stimulus.

## Interface
- `GATE_FN`, default 0: expected function. 0 NAND, 1 AND, 2 NOR, 3 OR.
- `SETTLE`, default 2: cycles each vector is held before sampling, range 1–15.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  starts a sweep; sampled only in IDLE.
- `abort`  in  1  cancels a running sweep.
- `p1a,p1b,p1c,p1d`  out  1 each  section-1 inputs, registered.
- `p2a,p2b,p2c,p2d`  out  1 each  section-2 inputs, registered.
- `p1y,p2y`  in  1 each  section outputs from the gate block.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `pass`  out  1  last completed sweep had zero mismatches.
- `fail_cnt`  out  6  mismatches in the current or last sweep, 0–32.
- `first_fail_vec`  out  4  vector index of the first mismatch.
- `first_fail_sec`  out  1  section of the first mismatch: 0 = section 1, 1 = section 2.

## Operation
- States:
  - IDLE: wait for `start`.
  - DRIVE: drive the current vector, run the wait counter.
  - SAMPLE: compare outputs against the model.
  - DONE: one cycle, assert `done`, return to IDLE.
- Vector counter `vec[3:0]`:
  - Section 1 drives {a,b,c,d} = vec[3:0].
  - Section 2 drives the bitwise inverse, ~vec[3:0].
  - Both sections therefore see all 16 combinations.
- IDLE behaviour:
  - All `p*` drive lines are 0.
  - On `start`: clear `fail_cnt`, `first_fail_*` and `pass`; set vec=0; go to DRIVE.
- DRIVE: stays SETTLE cycles, then goes to SAMPLE.
- SAMPLE compares `p1y` with model(vec) and `p2y` with model(~vec).
  - Each mismatch adds 1 to `fail_cnt`, so 0, 1 or 2 per vector.
  - The first mismatch of the sweep latches `first_fail_vec`=vec and the section.
  - If both sections mismatch on that same vector, section 1 takes priority and `first_fail_sec`=0.
- After SAMPLE:
  - If vec=15, go to DONE.
  - Otherwise vec+1 and back to DRIVE. There is no wrap-around.
- DONE: `pass`=1 if `fail_cnt`==0 after the final compare.
- `start` is ignored while `busy`=1.
- `abort` while busy:
  - Go to IDLE next cycle; drive lines return to 0.
  - No `done` pulse; `pass` stays 0.
  - `fail_cnt` and `first_fail_*` hold their partial values.
  - `abort` in IDLE has no effect.
- `abort` and `start` together in IDLE: `start` wins.
- `abort` on the DONE cycle is ignored; `done` still pulses.
- `first_fail_*` is 0 when there are no mismatches.

## Timing
- Reset (async, `rst_n`=0): state IDLE; all outputs 0, including `pass`, `fail_cnt` and `first_fail_*`. Reset mid-sweep aborts it immediately.
- `start` sampled at edge 0:
  - `busy`=1 and vector 0 is driven from edge 1.
  - Each vector occupies SETTLE+1 cycles: SETTLE in DRIVE, 1 in SAMPLE.
  - SAMPLE uses the `p*y` values present at that cycle's rising edge.
- DONE is entered 16·(SETTLE+1) cycles after edge 1; `done`=1 for that one cycle.
  - `busy` is 1 in DRIVE and SAMPLE only, so it is 0 on the `done` cycle.
  - With SETTLE=2: `busy` is high for 48 cycles, and `done` is the 49th cycle after `start`.
- Result outputs update on the SAMPLE edge and are stable in IDLE.
- A new `start` is accepted the cycle after DONE.

## Structure
- Package `gate_sweep_pkg`:
  - GATE_FN codes (FN_NAND=0, FN_AND=1, FN_NOR=2, FN_OR=3).
  - State encoding (S_IDLE, S_DRIVE, S_SAMPLE, S_DONE).
  - Vector width (4) and `fail_cnt` width (6).
- Sub-module `gate4_model` (combinational, parameter GATE_FN, 4-bit in, 1-bit out).
  - Instantiated twice, once per section.
  - Reused by the bench as its scoreboard.
- FSM, wait counter, vector counter and result registers live in `dual_gate_sweep_ctrl`.

## Test plan
- Correct NAND gate block, GATE_FN=0, SETTLE=2, pulse `start` -> `busy` high 48 cycles, `done` on cycle 49, `pass`=1, `fail_cnt`=0.
- `p1y` stuck at 1, other section correct -> `fail_cnt`=1, `first_fail_vec`=15, `first_fail_sec`=0, `pass`=0.
- `p2y` stuck at 0, section 1 correct -> `fail_cnt`=15, `first_fail_vec`=1, `first_fail_sec`=1.
- Both outputs inverted, i.e. an AND block tested with GATE_FN=0 -> `fail_cnt`=32, `first_fail_vec`=0, `first_fail_sec`=0.
- `abort` during vector 5 -> `busy`=0 next cycle, drive lines 0, no `done`.
  - A `start` pulse during the sweep has no effect.
  - A following `start` clears the results and completes normally.
- `rst_n` low during vector 9 -> all outputs 0 immediately, FSM in IDLE; the next `start` runs a full sweep.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the dual 4-input gate self-test sequencer.
// Gate function codes, FSM state encoding and datapath widths.
package gate_sweep_pkg;

    localparam int FN_NAND = 0;
    localparam int FN_AND  = 1;
    localparam int FN_NOR  = 2;
    localparam int FN_OR   = 3;

    localparam int VEC_W = 4;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/gate4_model.sv
// Golden 4-input gate: expected section output for a given input vector.
// Purely combinational, zero latency, no flow control.
module gate4_model
    import gate_sweep_pkg::*;
#(
    parameter int GATE_FN = FN_NAND
) (
    input  logic [VEC_W-1:0] x_i,
    output logic             y_o
);

    always_comb begin
        case (GATE_FN)
            FN_AND:  y_o = &x_i;
            FN_NOR:  y_o = ~|x_i;
            FN_OR:   y_o = |x_i;
            default: y_o = ~&x_i;
        endcase
    end

endmodule

// File: rtl/dual_gate_sweep_ctrl.sv
// Sweeps all 16 vectors through both gate sections and scores them against gate4_model.
// Each vector takes SETTLE+1 cycles; start is ignored while busy, abort returns to IDLE next cycle.
module dual_gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int GATE_FN = FN_NAND,
    parameter int SETTLE  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             p1a,
    output logic             p1b,
    output logic             p1c,
    output logic             p1d,
    output logic             p2a,
    output logic             p2b,
    output logic             p2c,
    output logic             p2d,
    input  logic             p1y,
    input  logic             p2y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic             first_fail_sec
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [VEC_W-1:0] VEC_LAST    = '1;

    state_t           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [3:0]       wait_q, wait_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [VEC_W-1:0] ffv_q, ffv_d;
    logic             ffs_q, ffs_d;
    logic             pass_q, pass_d;
    logic [VEC_W-1:0] drv1_q, drv1_d;
    logic [VEC_W-1:0] drv2_q, drv2_d;

    logic exp1, exp2, mis1, mis2;
    logic [VEC_W-1:0] vec_inv;

    assign vec_inv = ~vec_q;

    gate4_model #(.GATE_FN(GATE_FN)) u_model_sec1 (
        .x_i (vec_q),
        .y_o (exp1)
    );

    gate4_model #(.GATE_FN(GATE_FN)) u_model_sec2 (
        .x_i (vec_inv),
        .y_o (exp2)
    );

    assign mis1 = p1y ^ exp1;
    assign mis2 = p2y ^ exp2;

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        wait_d     = wait_q;
        fail_cnt_d = fail_cnt_q;
        ffv_d      = ffv_q;
        ffs_d      = ffs_q;
        pass_d     = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_DRIVE;
                    vec_d      = '0;
                    wait_d     = '0;
                    fail_cnt_d = '0;
                    ffv_d      = '0;
                    ffs_d      = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            S_DRIVE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (wait_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    fail_cnt_d = fail_cnt_q + CNT_W'(mis1) + CNT_W'(mis2);
                    // An empty count means nothing has been latched yet this sweep.
                    if (fail_cnt_q == '0) begin
                        if (mis1) begin
                            ffv_d = vec_q;
                            ffs_d = 1'b0;
                        end else if (mis2) begin
                            ffv_d = vec_q;
                            ffs_d = 1'b1;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        state_d = S_DONE;
                        pass_d  = (fail_cnt_d == '0);
                    end else begin
                        state_d = S_DRIVE;
                        vec_d   = vec_q + 4'd1;
                        wait_d  = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        drv1_d = '0;
        drv2_d = '0;
        if (state_d == S_DRIVE || state_d == S_SAMPLE) begin
            drv1_d = vec_d;
            drv2_d = ~vec_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            vec_q      <= '0;
            wait_q     <= '0;
            fail_cnt_q <= '0;
            ffv_q      <= '0;
            ffs_q      <= 1'b0;
            pass_q     <= 1'b0;
            drv1_q     <= '0;
            drv2_q     <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            wait_q     <= wait_d;
            fail_cnt_q <= fail_cnt_d;
            ffv_q      <= ffv_d;
            ffs_q      <= ffs_d;
            pass_q     <= pass_d;
            drv1_q     <= drv1_d;
            drv2_q     <= drv2_d;
        end
    end

    assign {p1a, p1b, p1c, p1d} = drv1_q;
    assign {p2a, p2b, p2c, p2d} = drv2_q;

    assign busy           = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign done           = (state_q == S_DONE);
    assign pass           = pass_q;
    assign fail_cnt       = fail_cnt_q;
    assign first_fail_vec = ffv_q;
    assign first_fail_sec = ffs_q;

endmodule

// File: tb/tb_dual_gate_sweep_ctrl.sv
// Randomized and directed sweeps of dual_gate_sweep_ctrl against a fault-injecting NAND block.
// Expected results come from a per-vector fault-mask model of the sweep.
module tb_dual_gate_sweep_ctrl;

    localparam int SETTLE = 2;
    localparam int VEC_CYC = SETTLE + 1;
    localparam int BUSY_CYC = 16 * VEC_CYC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic p1a, p1b, p1c, p1d, p2a, p2b, p2c, p2d;
    logic p1y, p2y;
    logic busy, done, pass;
    logic [5:0] fail_cnt;
    logic [3:0] first_fail_vec;
    logic first_fail_sec;

    logic [15:0] mask1 = '0;
    logic [15:0] mask2 = '0;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dual_gate_sweep_ctrl #(.GATE_FN(0), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .p1a(p1a), .p1b(p1b), .p1c(p1c), .p1d(p1d),
        .p2a(p2a), .p2b(p2b), .p2c(p2c), .p2d(p2d),
        .p1y(p1y), .p2y(p2y),
        .busy(busy), .done(done), .pass(pass),
        .fail_cnt(fail_cnt), .first_fail_vec(first_fail_vec),
        .first_fail_sec(first_fail_sec)
    );

    // Gate block under test: a NAND with a per-input-combination flip mask.
    function automatic logic nand_ref(input logic [3:0] x);
        return $countones(x) != 4;
    endfunction

    assign p1y = nand_ref({p1a, p1b, p1c, p1d}) ^ mask1[{p1a, p1b, p1c, p1d}];
    assign p2y = nand_ref({p2a, p2b, p2c, p2d}) ^ mask2[{p2a, p2b, p2c, p2d}];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Score the first nvec vectors: section 2 sees input 15-v while section 1 sees v.
    task automatic sweep_model(input logic [15:0] m1, input logic [15:0] m2, input int nvec,
                               output int cnt, output int fv, output int fs);
        cnt = 0; fv = 0; fs = 0;
        for (int v = 0; v < nvec; v++) begin
            if (cnt == 0 && m1[v]) begin
                fv = v; fs = 0;
            end else if (cnt == 0 && m2[15 - v]) begin
                fv = v; fs = 1;
            end
            cnt += int'(m1[v]) + int'(m2[15 - v]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {busy, done, pass, fail_cnt, first_fail_vec, first_fail_sec,
                    p1a, p1b, p1c, p1d, p2a, p2b, p2c, p2d}, 0);
    endtask

    // abort_cyc / rst_cyc / noise_cyc are cycle numbers after the start edge; <=0 disables.
    task automatic do_sweep(input logic [15:0] m1, input logic [15:0] m2,
                            input int abort_cyc, input int rst_cyc, input int noise_cyc,
                            input logic both);
        int busy_n = 0;
        int done_at = -1;
        int seq_err = 0;
        int cnt, fv, fs, nvec;
        logic aborted;
        logic [3:0] ev;
        aborted = (abort_cyc >= 1) && (abort_cyc <= BUSY_CYC);
        mask1 = m1;
        mask2 = m2;
        @(negedge clk);
        start = 1'b1;
        abort = both;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("busy_after_start", busy, 1);
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) @(negedge clk);
            if (busy) begin
                busy_n++;
                ev = 4'((c - 1) / VEC_CYC);
                if (c > BUSY_CYC || {p1a, p1b, p1c, p1d} != ev || {p2a, p2b, p2c, p2d} != ~ev)
                    seq_err++;
            end else if ({p1a, p1b, p1c, p1d, p2a, p2b, p2c, p2d} != 8'd0) begin
                seq_err++;
            end
            if (done && done_at < 0) done_at = c;
            if (c == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("reset_mid_sweep");
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check("idle_after_reset", busy, 0);
                return;
            end
            start = (c == noise_cyc);
            abort = (c == abort_cyc);
        end
        start = 1'b0;
        abort = 1'b0;
        nvec = aborted ? (abort_cyc - 1) / VEC_CYC : 16;
        sweep_model(m1, m2, nvec, cnt, fv, fs);
        check("drive_seq_errs", seq_err, 0);
        check("busy_cycles", busy_n, aborted ? abort_cyc : BUSY_CYC);
        check("done_cycle", done_at, aborted ? -1 : BUSY_CYC + 1);
        check("fail_cnt", fail_cnt, cnt);
        check("first_fail_vec", first_fail_vec, fv);
        check("first_fail_sec", first_fail_sec, fs);
        check("pass", pass, (!aborted && cnt == 0) ? 1 : 0);
    endtask

    initial begin
        int ab, nz, lim, mode;
        logic [15:0] ma, mb;
        #2;
        check_all_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_release");

        // Correct block; abort on the DONE cycle and later in IDLE has no effect.
        do_sweep(16'h0000, 16'h0000, BUSY_CYC + 1, 0, 0, 1'b0);
        do_sweep(16'h0000, 16'h0000, 55, 0, 20, 1'b1);
        // p1y stuck at 1, p2y stuck at 0, both inverted.
        do_sweep(16'h8000, 16'h0000, 0, 0, 0, 1'b0);
        do_sweep(16'h0000, 16'h7FFF, 0, 0, 0, 1'b0);
        do_sweep(16'hFFFF, 16'hFFFF, 0, 0, 0, 1'b0);
        // Abort in vector 5 with an ignored start earlier, then a clean rerun.
        do_sweep(16'h0421, 16'h1200, 5 * VEC_CYC + 1, 0, 8, 1'b0);
        check("no_restart_after_abort", busy, 0);
        do_sweep(16'h0421, 16'h1200, 0, 0, 0, 1'b0);
        // Reset in vector 9, then a full sweep.
        do_sweep(16'hFFFF, 16'h0000, 0, 9 * VEC_CYC + 1, 0, 1'b0);
        do_sweep(16'h0100, 16'h0000, 0, 0, 0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            mode = $urandom_range(0, 3);
            case (mode)
                0: begin ma = 16'h0; mb = 16'($urandom) & 16'($urandom) & 16'($urandom); end
                1: begin ma = 16'($urandom) & 16'($urandom); mb = 16'($urandom) & 16'($urandom); end
                2: begin ma = 16'($urandom); mb = 16'($urandom); end
                default: begin ma = 16'(1 << $urandom_range(0, 15)); mb = 16'(1 << $urandom_range(0, 15)); end
            endcase
            ab = 0;
            if ($urandom_range(0, 1) == 1)
                ab = VEC_CYC * $urandom_range(0, 15) + $urandom_range(1, SETTLE);
            lim = (ab > 0) ? ab - 1 : BUSY_CYC - 1;
            nz = (lim >= 2) ? $urandom_range(2, lim) : 0;
            do_sweep(ma, mb, ab, 0, nz, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
